// File: rtl/hub75_column_driver.sv
// HUB75 row shifter: fetches each column of one display row, reduces the pixel to
// one bit per channel for the latched bit-plane, clocks it out, then latches the row.
module hub75_column_driver #(
  parameter int COLUMNS   = 64,
  parameter int LOAD_WAIT = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  bitplane,
  input  logic [15:0] rgb565_top,
  input  logic [15:0] rgb565_bottom,
  output logic [5:0]  column_address,
  output logic        pixel_load_start,
  output logic [2:0]  rgb1,
  output logic [2:0]  rgb2,
  output logic        pixel_clock,
  output logic        row_latch,
  output logic        busy,
  output logic        done
);

  localparam int WW = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
  localparam logic [5:0] LAST_COL = 6'(COLUMNS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CLK_HI = 3'd4;
  localparam logic [2:0] S_LATCH  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // Plane p selects R=px[11+p], G=px[6+p] (green LSB dropped), B=px[p]; p is at most 4.
  function automatic logic [2:0] plane_bits(input logic [15:0] px, input logic [2:0] p);
    logic [3:0] pi;
    pi = {1'b0, p};
    return {px[4'd11 + pi], px[4'd6 + pi], px[pi]};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [5:0]    column_q, column_d;
  logic [2:0]    plane_q, plane_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [2:0]    rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic          pls_q, pls_d, pclk_q, pclk_d, latch_q, latch_d;
  logic          busy_q, busy_d, done_q, done_d;

  // Next-state, counters and pixel capture on the edge that enters DATA.
  always_comb begin
    state_d  = state_q;
    column_d = column_q;
    plane_d  = plane_q;
    wait_d   = wait_q;
    rgb1_d   = rgb1_q;
    rgb2_d   = rgb2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          column_d = 6'd0;
          plane_d  = (bitplane > 3'd4) ? 3'd4 : bitplane;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
        wait_d  = WW'(LOAD_WAIT - 1);
      end
      S_WAIT: begin
        if (wait_q == {WW{1'b0}}) begin
          state_d = S_DATA;
          rgb1_d  = plane_bits(rgb565_top, plane_q);
          rgb2_d  = plane_bits(rgb565_bottom, plane_q);
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      S_DATA:   state_d = S_CLK_HI;
      S_CLK_HI: begin
        if (column_q == LAST_COL) begin
          state_d = S_LATCH;
        end else begin
          column_d = column_q + 6'd1;
          state_d  = S_LOAD;
        end
      end
      S_LATCH:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they are registered with it.
  always_comb begin
    pls_d   = (state_d == S_LOAD);
    pclk_d  = (state_d == S_CLK_HI);
    latch_d = (state_d == S_LATCH);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any row in progress.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      column_q <= 6'd0;
      plane_q  <= 3'd0;
      wait_q   <= {WW{1'b0}};
      rgb1_q   <= 3'd0;
      rgb2_q   <= 3'd0;
      pls_q    <= 1'b0;
      pclk_q   <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      column_q <= column_d;
      plane_q  <= plane_d;
      wait_q   <= wait_d;
      rgb1_q   <= rgb1_d;
      rgb2_q   <= rgb2_d;
      pls_q    <= pls_d;
      pclk_q   <= pclk_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign column_address   = column_q;
  assign pixel_load_start = pls_q;
  assign rgb1             = rgb1_q;
  assign rgb2             = rgb2_q;
  assign pixel_clock      = pclk_q;
  assign row_latch        = latch_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
